bfloat_mul_seq: RTL and testbench

//   Multi-cycle bfloat16 multiplier; the multiplication counterpart of the bfloat16 divider.
//   - Shift-add datapath: 8x8 mantissa product, one multiplier bit per cycle.
//   - Sits beside the divider in the arithmetic unit, with valid/ready on both sides.
//   - Uses the divider's special-value encodings so the two units are interchangeable.

---
 rtl/bfloat_mul_seq.sv | 183 ++++++++++++++++++
 tb/tb_bfloat_mul_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bfloat_mul_seq.sv
// +----------------------------------------------------------------------------+
// | Module : bfloat_mul_seq                                                    |
// | Multi-cycle bfloat16 multiplier, shift-add mantissa product, valid/ready.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bfloat_mul_seq #(
    parameter logic [15:0] NAN_OUT  = 16'hFFFF,
    parameter int          EXP_BIAS = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] c,
    output logic        ovf,
    output logic        unf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic signed [9:0] c_bias = 10'(EXP_BIAS);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sc;
    logic [7:0]  r_ea;
    logic [7:0]  r_eb;
    logic [7:0]  r_ma;
    logic [7:0]  r_mb;
    logic [15:0] r_acc;
    logic [2:0]  r_cnt;
    logic [15:0] r_c;
    logic        r_ovf;
    logic        r_unf;

    // Operand classification; exponent 0 counts as zero (denormals flushed)
    logic        w_a_zero, w_a_inf, w_a_nan;
    logic        w_b_zero, w_b_inf, w_b_nan;
    logic        w_sc;
    logic        w_special;
    logic        w_accept;
    logic [15:0] w_special_c;

    assign w_a_zero  = (a[14:7] == 8'h00);
    assign w_a_inf   = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
    assign w_a_nan   = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
    assign w_b_zero  = (b[14:7] == 8'h00);
    assign w_b_inf   = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
    assign w_b_nan   = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
    assign w_sc      = a[15] ^ b[15];
    assign w_special = w_a_zero | w_a_inf | w_a_nan | w_b_zero | w_b_inf | w_b_nan;
    assign w_accept  = in_valid && (r_state == S_IDLE);

    always_comb begin
        w_special_c = {w_sc, 15'h0000};
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_special_c = NAN_OUT;
        end else if (w_a_inf || w_b_inf) begin
            w_special_c = {w_sc, 8'hFF, 7'h00};
        end
    end

    logic [15:0]       w_addend;
    logic signed [9:0] w_e_sum;
    logic signed [9:0] w_e_norm;
    logic [6:0]        w_man;

    assign w_addend = {8'h00, r_ma} << r_cnt;
    assign w_e_sum  = $signed({2'b00, r_ea}) + $signed({2'b00, r_eb}) - c_bias;
    assign w_e_norm = w_e_sum + $signed({9'd0, r_acc[15]});
    assign w_man    = r_acc[15] ? r_acc[14:8] : r_acc[13:7];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = w_special ? S_DONE : S_MUL;
                end
            end
            S_MUL: begin
                if (r_cnt == 3'd7) begin
                    w_state_nxt = S_NORM;
                end
            end
            S_NORM: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sc  <= 1'b0;
            r_ea  <= 8'h00;
            r_eb  <= 8'h00;
            r_ma  <= 8'h00;
            r_mb  <= 8'h00;
            r_acc <= 16'h0000;
            r_cnt <= 3'd0;
            r_c   <= 16'h0000;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sc  <= w_sc;
                        r_ea  <= a[14:7];
                        r_eb  <= b[14:7];
                        r_ma  <= {1'b1, a[6:0]};
                        r_mb  <= {1'b1, b[6:0]};
                        r_acc <= 16'h0000;
                        r_cnt <= 3'd0;
                        r_ovf <= 1'b0;
                        r_unf <= 1'b0;
                        if (w_special) begin
                            r_c <= w_special_c;
                        end
                    end
                end
                S_MUL: begin
                    if (r_mb[r_cnt]) begin
                        r_acc <= r_acc + w_addend;
                    end
                    r_cnt <= r_cnt + 3'd1;
                end
                S_NORM: begin
                    // Truncating normalisation; saturate or flush at the exponent limits
                    if (w_e_norm >= 10'sd255) begin
                        r_c   <= {r_sc, 8'hFF, 7'h00};
                        r_ovf <= 1'b1;
                    end else if (w_e_norm <= 10'sd0) begin
                        r_c   <= {r_sc, 15'h0000};
                        r_unf <= 1'b1;
                    end else begin
                        r_c <= {r_sc, w_e_norm[7:0], w_man};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign c   = r_c;
    assign ovf = r_ovf;
    assign unf = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_bfloat_mul_seq.sv
// +----------------------------------------------------------------------------+
// | Module : tb_bfloat_mul_seq                                                 |
// | Randomised bench for bfloat_mul_seq against an arithmetic reference model. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_bfloat_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] c;
    logic        ovf;
    logic        unf;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bfloat_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .ovf       (ovf),
        .unf       (unf)
    );

    // Returns {special, ovf, unf, c} using plain integer arithmetic
    function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y);
        int  ex, ey, mx, my, p, e, m;
        logic sc, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
        ex = int'(x[14:7]);  ey = int'(y[14:7]);
        mx = int'(x[6:0]);   my = int'(y[6:0]);
        sc = x[15] ^ y[15];
        x_nan = (ex == 255) && (mx != 0);  y_nan = (ey == 255) && (my != 0);
        x_inf = (ex == 255) && (mx == 0);  y_inf = (ey == 255) && (my == 0);
        x_zero = (ex == 0);                y_zero = (ey == 0);
        if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero))
            return {3'b100, 16'hFFFF};
        if (x_inf || y_inf)
            return {3'b100, sc, 8'hFF, 7'h00};
        if (x_zero || y_zero)
            return {3'b100, sc, 15'h0000};
        p = (128 + mx) * (128 + my);
        e = ex + ey - 127;
        if (p >= 32768) begin
            e = e + 1;
            m = (p / 256) % 128;
        end else begin
            m = (p / 128) % 128;
        end
        if (e >= 255) return {3'b010, sc, 8'hFF, 7'h00};
        if (e <= 0)   return {3'b001, sc, 15'h0000};
        return {3'b000, sc, 8'(e), 7'(m)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    logic        have_exp = 1'b0;
    logic [18:0] exp_r = '0;

    // Output checker: compares every valid cycle against the model of the accepted op
    always @(negedge clk) begin
        check("ready_valid_overlap", 32'(in_ready & out_valid), 32'd0);
        if (out_valid) begin
            if (!have_exp) begin
                check("spurious_out_valid", 32'(have_exp), 32'd1);
            end else begin
                check("c",   32'(c),   32'(exp_r[15:0]));
                check("ovf", 32'(ovf), 32'(exp_r[17]));
                check("unf", 32'(unf), 32'(exp_r[16]));
            end
        end
        if (!rst_n) begin
            have_exp = 1'b0;
        end else if (in_valid && in_ready) begin
            exp_r    = model(a, b);
            have_exp = 1'b1;
        end else if (out_valid && out_ready) begin
            have_exp = 1'b0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input int stall, input bit pulse);
        logic [18:0] m;
        logic [15:0] held;
        int          n;
        m = model(x, y);
        wait_ready();
        a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), m[18] ? 32'd1 : 32'd10);
        held = c;
        for (int i = 0; i < stall; i++) begin
            if (pulse) begin
                in_valid = (i < 2);
                a = 16'($urandom); b = 16'($urandom);
            end
            @(posedge clk); #1;
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_c_stable", 32'(c), 32'(held));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
    endtask

    function automatic logic [15:0] rand_bf();
        int r;
        logic [7:0] e;
        r = $urandom_range(0, 9);
        if (r == 0)      e = 8'h00;
        else if (r == 1) e = 8'hFF;
        else if (r == 2) e = 8'($urandom_range(1, 20));
        else if (r == 3) e = 8'($urandom_range(235, 254));
        else             e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, (r == 1 && $urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom)};
    endfunction

    initial begin
        logic [18:0] m;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_c",         32'(c),         32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_unf",       32'(unf),       32'd0);
        rst_n = 1'b1;

        m = model(16'h4040, 16'h4000); check("model_t1",  32'(m), 32'h040C0);
        m = model(16'h3FC0, 16'hBFC0); check("model_t2",  32'(m), 32'h0C010);
        m = model(16'h7F80, 16'h0000); check("model_t3a", 32'(m), 32'h4FFFF);
        m = model(16'h7F80, 16'hC000); check("model_t3b", 32'(m), 32'h4FF80);
        m = model(16'h7F00, 16'h4000); check("model_t4a", 32'(m), 32'h27F80);
        m = model(16'h0080, 16'h3F00); check("model_t4b", 32'(m), 32'h10000);

        run_op(16'h4040, 16'h4000, 0, 1'b0);
        check("t1_c", 32'(c), 32'h40C0);
        run_op(16'h3FC0, 16'hBFC0, 0, 1'b0);
        run_op(16'h7F80, 16'h0000, 0, 1'b0);
        run_op(16'h7F80, 16'hC000, 0, 1'b0);
        run_op(16'h7F00, 16'h4000, 0, 1'b0);
        check("t4a_ovf_held", 32'(ovf), 32'd1);
        run_op(16'h0080, 16'h3F00, 0, 1'b0);
        run_op(16'h3FC0, 16'h4040, 5, 1'b1);

        // Reset during the fourth multiply cycle
        wait_ready();
        a = 16'h4040; b = 16'h4000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_c",         32'(c),         32'd0);
        check("t6_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;
        run_op(16'h4040, 16'h4000, 0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            run_op(rand_bf(), rand_bf(), $urandom_range(0, 3), 1'($urandom));
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
